pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces per-bit enable-only stage registers with a valid/ready handshake backed by a 2-entry skid buffer, so that back-pressure `in_ready` is a registered signal. It also provides a synchronous flush for branch squash and bubble masking of control fields. All stages of the pipeline instantiate it with their own `WIDTH` and `CTRL_MASK`.

## Interface
Parameters:
- `WIDTH`, default 60: payload width in bits (≥1).
- `CTRL_MASK`, default `{WIDTH{1'b0}}`: payload bits that are control signals (RegWrite, MemToReg, MemWrite, …). They are forced to 0 on `out_data` whenever `out_valid`=0.
- `RESET_VAL`, default `{WIDTH{1'b0}}`: reset contents of both data registers.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash. Highest priority.
- `in_valid` in 1: upstream holds a valid payload.
- `in_ready` out 1: stage can accept; registered.
- `in_data` in `WIDTH`: upstream payload.
- `out_valid` out 1: `out_data` is valid; registered.
- `out_ready` in 1: downstream accepts this cycle.
- `out_data` out `WIDTH`: payload to the next stage.
- `count` out 2: entries held (0..2); registered.

## Operation
- Storage: `main` register (drives `out_data`) and `skid` register. Both are `WIDTH` wide.
- `push` = `in_valid & in_ready`. `pop` = `out_valid & out_ready`.
- States are encoded by `count`:
  - EMPTY (0): `out_valid`=0, `in_ready`=1.
  - ONE (1): `out_valid`=1, `in_ready`=1.
  - FULL (2): `out_valid`=1, `in_ready`=0.
- Transitions, when `flush`=0:
  - EMPTY: push → ONE, `main`←`in_data`. No push → stay.
  - ONE: push & !pop → FULL, `skid`←`in_data`. push & pop → ONE, `main`←`in_data`. !push & pop → EMPTY. Neither → hold.
  - FULL: pop → ONE, `main`←`skid`. No pop → hold. push is impossible because `in_ready`=0.
- flush=1:
  - Next state is EMPTY regardless of push or pop.
  - A payload presented the same cycle is discarded, even though `in_ready`=1 made it look accepted. Upstream must treat flush as squashing its own stage too.
  - Data registers are not cleared. Only the state changes.
- `out_data` is combinational:
  - = `main` when `out_valid`=1.
  - = `main & ~CTRL_MASK` when `out_valid`=0.
  - An empty or flushed stage therefore presents a bubble with all control bits zero.
- Data registers update only as listed above. Otherwise they hold, so no spurious toggling.
- Never: `in_ready`=1 while `count`=2, `out_valid`=1 while `count`=0, or a payload lost or duplicated outside flush.
- Payload order is strictly FIFO.

## Timing
- Reset, asynchronous assert with release synchronous to `clk`:
  - `count`=0, `out_valid`=0, `in_ready`=1.
  - `main`=`skid`=`RESET_VAL`.
  - `out_data`=`RESET_VAL & ~CTRL_MASK`.
- Reset mid-transfer drops all held entries immediately, without waiting for a clock edge.
- Latency: a payload pushed at edge N appears on `out_data` with `out_valid`=1 after edge N, when the stage was EMPTY or ONE with pop.
- Throughput: 1 payload/cycle sustained while `out_ready`=1.
- No combinational path from `out_ready` or `in_valid` to `in_ready` or `out_valid`.
- The only combinational input-to-output path is `main`/state → `out_data` (mask).
- Stall: deasserting `out_ready` fills the skid on the next push. `in_ready` falls at the following edge. One extra payload is absorbed, no loss.
- Simultaneous flush and reset: reset wins.
- Simultaneous flush and push in EMPTY: the stage stays EMPTY.

## Test plan
All scenarios use `WIDTH`=60, `CTRL_MASK`=60'hF00000000000000, `RESET_VAL`=0.
- Reset: assert `rst`=0 mid-cycle with `count`=2 → `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0 before the next edge.
- Streaming: push 0x1..0x8 on consecutive cycles with `out_ready`=1 → `out_data` 0x1..0x8 on consecutive cycles, one cycle after each push. `count` stays 1 and `in_ready` stays 1.
- Back-pressure: `out_ready`=0 from cycle 3 while pushing 0xA, 0xB, 0xC → `count` goes 1→2, `in_ready`=0 after 0xB is accepted, and 0xC is held upstream. Then `out_ready`=1 → outputs 0xA, 0xB, 0xC in order with no gaps.
- Flush: `count`=2 holding 0xF00000000000055, flush with `in_valid`=1 → next cycle `count`=0, `out_valid`=0, `out_data`=0x000000000000055 (control nibble masked). The flush-cycle payload never appears.
- Simultaneous push/pop in ONE: `main`=0x11, push 0x22 with `out_ready`=1 → after the edge `out_data`=0x22, `count`=1.
- Random: random `in_valid`/`out_ready`/rare flush for 10k cycles against a scoreboard FIFO model → no loss, duplication or reorder outside flush windows, and control bits are 0 whenever `out_valid`=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline-stage register with a 2-entry skid buffer,
// synchronous flush and control-bit masking of bubbles.
module pipe_stage_reg #(
    parameter int               WIDTH     = 60,
    parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             push, pop;
    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign count     = state_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? main_q : (main_q & ~CTRL_MASK);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
                ONE: if (push && !pop) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (push) begin
                    main_d = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus; a queue-based reference model is checked
// by a negedge monitor that pops expected payloads whenever the stage delivers one.
module tb_pipe_stage_reg;
    localparam int          W    = 60;
    localparam logic [W-1:0] MASK = 60'hF00000000000000;
    logic         clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid;
    logic [W-1:0] in_data = '0, out_data;
    logic [1:0]   count;
    logic [W-1:0] q[$];
    int           m_cnt = 0;
    int           n_chk = 0, n_fail = 0;

    pipe_stage_reg #(.WIDTH(W), .CTRL_MASK(MASK), .RESET_VAL('0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; an accepted, unflushed payload is queued as expected output.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid = v; in_data = d; out_ready = r; flush = f;
        if (v && m_cnt < 2 && !f) q.push_back(d);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            int p, o;
            logic [W-1:0] e;
            chk("count", 64'(count), 64'(m_cnt));
            chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
            chk("in_ready", 64'(in_ready), 64'(m_cnt < 2));
            if (m_cnt == 0) chk("bubble_ctrl", 64'(out_data & MASK), 64'd0);
            p = (in_valid && m_cnt < 2) ? 1 : 0;
            o = (out_ready && m_cnt > 0) ? 1 : 0;
            if (o == 1) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard_underflow: got 0x%0h expected none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("payload", 64'(out_data), 64'(e));
                end
            end
            m_cnt = flush ? 0 : m_cnt + p - o;
            if (flush) q.delete();
        end
    end

    initial begin
        logic [63:0] r64;
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        // Asynchronous reset while FULL
        cyc(1'b1, 60'hF00000000000123, 1'b0, 1'b0);
        cyc(1'b1, 60'h456, 1'b0, 1'b0);
        chk("full_before_rst", 64'(count), 64'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        // Streaming
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_data", 64'(out_data), 64'(i));
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        // Back-pressure
        cyc(1'b1, 60'hA, 1'b0, 1'b0);
        chk("bp_count_a", 64'(count), 64'd1);
        cyc(1'b1, 60'hB, 1'b0, 1'b0);
        chk("bp_count_b", 64'(count), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 60'hC, 1'b0, 1'b0);
        chk("bp_hold_count", 64'(count), 64'd2);
        cyc(1'b1, 60'hC, 1'b1, 1'b0);
        chk("bp_drain_b", 64'(out_data), 64'hB);
        cyc(1'b1, 60'hC, 1'b1, 1'b0);
        chk("bp_drain_c", 64'(out_data), 64'hC);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", 64'(count), 64'd0);
        // Flush while FULL
        cyc(1'b1, 60'hF00000000000055, 1'b0, 1'b0);
        cyc(1'b1, 60'h77, 1'b0, 1'b0);
        cyc(1'b1, 60'h99, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_data", 64'(out_data), 64'h55);
        cyc(1'b1, 60'hF000000000000AB, 1'b1, 1'b1);
        chk("flush_push_empty", 64'(count), 64'd0);
        // Simultaneous push and pop in ONE
        cyc(1'b1, 60'h11, 1'b1, 1'b0);
        cyc(1'b1, 60'h22, 1'b1, 1'b0);
        chk("pushpop_data", 64'(out_data), 64'h22);
        chk("pushpop_count", 64'(count), 64'd1);
        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            r64 = {$urandom, $urandom};
            cyc($urandom_range(0, 99) < 60, r64[W-1:0], $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 2);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drained", 64'(count), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
